// File: rtl/spi_flash_reader_if.sv
// rtl/spi_flash_reader_if.sv - byte handoff bundle between the SPI flash reader and its consumer
interface spi_flash_reader_if;
  logic [7:0] data_o;
  logic       data_valid_o;
  logic       data_ready_i;

  modport master (
    output data_o,
    output data_valid_o,
    input  data_ready_i
  );

  modport slave (
    input  data_o,
    input  data_valid_o,
    output data_ready_i
  );
endinterface

// File: rtl/spi_flash_reader.sv
// rtl/spi_flash_reader.sv - mode-0 SPI master issuing READ (0x03) and streaming bytes out
module spi_flash_reader #(
  parameter int CLK_DIV = 4,
  parameter int ADDR_W  = 24,
  parameter int LEN_W   = 16
) (
  input  logic                  master_clk_i,
  input  logic                  master_rst_i,
  input  logic                  start_i,
  input  logic [ADDR_W-1:0]     start_addr_i,
  input  logic [LEN_W-1:0]      byte_count_i,
  output logic                  busy_o,
  output logic                  done_o,
  spi_flash_reader_if.master    rd_if,
  output logic                  SS,
  output logic                  SCK_SPI,
  output logic                  MOSI,
  input  logic                  MISO
);

  localparam int HDR_W = 8 + ADDR_W;
  localparam int HCW   = $clog2(HDR_W);
  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int GW    = $clog2(CLK_DIV + 1);

  localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(CLK_DIV - 1);
  localparam logic [HCW-1:0]   HDR_CMD  = HCW'(7);
  localparam logic [HCW-1:0]   HDR_LAST = HCW'(HDR_W - 1);
  localparam logic [7:0]       CMD_READ = 8'h03;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_DATA,
    S_HOLD,
    S_FINISH
  } state_e;

  state_e             state_q, state_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic               sck_q, sck_d;
  logic               ss_q, ss_d;
  logic               mosi_q, mosi_d;
  logic [HDR_W-1:0]   sh_q, sh_d;
  logic [HCW-1:0]     hdr_q, hdr_d;
  logic [2:0]         bit_q, bit_d;
  logic [7:0]         rx_q, rx_d;
  logic [LEN_W-1:0]   rem_q, rem_d;
  logic [7:0]         dout_q, dout_d;
  logic               dvalid_q, dvalid_d;
  logic               done_q, done_d;
  logic [GW-1:0]      guard_q, guard_d;

  logic               tick;
  logic               capture;
  logic               consume;
  logic [HDR_W-1:0]   hdr_word;

  assign tick     = (div_q == DIV_MAX);
  assign consume  = dvalid_q & rd_if.data_ready_i;
  assign hdr_word = {CMD_READ, start_addr_i};

  always_ff @(posedge master_clk_i) begin
    if (!master_rst_i) begin
      state_q  <= S_IDLE;
      div_q    <= '0;
      sck_q    <= 1'b0;
      ss_q     <= 1'b1;
      mosi_q   <= 1'b0;
      sh_q     <= '0;
      hdr_q    <= '0;
      bit_q    <= '0;
      rx_q     <= '0;
      rem_q    <= '0;
      dout_q   <= '0;
      dvalid_q <= 1'b0;
      done_q   <= 1'b0;
      guard_q  <= '0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      sck_q    <= sck_d;
      ss_q     <= ss_d;
      mosi_q   <= mosi_d;
      sh_q     <= sh_d;
      hdr_q    <= hdr_d;
      bit_q    <= bit_d;
      rx_q     <= rx_d;
      rem_q    <= rem_d;
      dout_q   <= dout_d;
      dvalid_q <= dvalid_d;
      done_q   <= done_d;
      guard_q  <= guard_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    sck_d    = sck_q;
    ss_d     = ss_q;
    mosi_d   = mosi_q;
    sh_d     = sh_q;
    hdr_d    = hdr_q;
    bit_d    = bit_q;
    rx_d     = rx_q;
    rem_d    = rem_q;
    dout_d   = dout_q;
    dvalid_d = dvalid_q;
    done_d   = 1'b0;
    guard_d  = guard_q;
    capture  = 1'b0;

    if (consume) begin
      dvalid_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (guard_q != '0) begin
          guard_d = guard_q - GW'(1);
        end
        // done_q high means busy_o is still asserted, so a start here is ignored
        if (start_i && !done_q) begin
          if (byte_count_i == '0) begin
            done_d = 1'b1;
          end else if (guard_q == '0) begin
            state_d = S_CMD;
            ss_d    = 1'b0;
            sh_d    = hdr_word;
            mosi_d  = hdr_word[HDR_W-1];
            rem_d   = byte_count_i;
            div_d   = '0;
            sck_d   = 1'b0;
            hdr_d   = '0;
            bit_d   = '0;
          end
        end
      end

      S_CMD, S_ADDR, S_DATA: begin
        div_d = tick ? '0 : div_q + DIV_W'(1);
        if (tick) begin
          sck_d = ~sck_q;
          if (!sck_q) begin
            if (state_q == S_DATA) begin
              rx_d = {rx_q[6:0], MISO};
            end
          end else if (state_q == S_DATA) begin
            bit_d = bit_q + 3'd1;
            if (bit_q == 3'd7) begin
              // Byte done: park with SCK low if the consumer still owns data_o
              if (dvalid_q && !rd_if.data_ready_i) begin
                state_d = S_HOLD;
                bit_d   = bit_q;
              end else begin
                capture = 1'b1;
              end
            end
          end else begin
            sh_d   = {sh_q[HDR_W-2:0], 1'b0};
            mosi_d = sh_q[HDR_W-2];
            hdr_d  = hdr_q + HCW'(1);
            if (state_q == S_CMD && hdr_q == HDR_CMD) begin
              state_d = S_ADDR;
            end
            if (state_q == S_ADDR && hdr_q == HDR_LAST) begin
              state_d = S_DATA;
              mosi_d  = 1'b0;
              hdr_d   = '0;
              bit_d   = '0;
            end
          end
        end
      end

      S_HOLD: begin
        if (!dvalid_q || rd_if.data_ready_i) begin
          capture = 1'b1;
        end
      end

      S_FINISH: begin
        if (!dvalid_q) begin
          state_d = S_IDLE;
          ss_d    = 1'b1;
          done_d  = 1'b1;
          guard_d = GW'(CLK_DIV);
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A capture may coincide with a consume; the new byte simply replaces the old one
    if (capture) begin
      dout_d   = rx_q;
      dvalid_d = 1'b1;
      rem_d    = rem_q - LEN_W'(1);
      bit_d    = '0;
      div_d    = '0;
      state_d  = (rem_q == LEN_W'(1)) ? S_FINISH : S_DATA;
    end
  end

  assign busy_o             = (state_q != S_IDLE) | done_q;
  assign done_o             = done_q;
  assign rd_if.data_o       = dout_q;
  assign rd_if.data_valid_o = dvalid_q;
  assign SS                 = ss_q;
  assign SCK_SPI            = sck_q;
  assign MOSI               = mosi_q;

endmodule

// File: tb/tb_spi_flash_reader.sv
// tb/tb_spi_flash_reader.sv - directed bench with a mode-0 flash model and byte consumer monitor
module tb_spi_flash_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [23:0] start_addr;
  logic [15:0] byte_count;
  logic        busy;
  logic        done;
  logic        ss;
  logic        sck;
  logic        mosi;
  logic        miso = 1'b0;

  spi_flash_reader_if bus ();

  spi_flash_reader #(.CLK_DIV(4), .ADDR_W(24), .LEN_W(16)) dut (
    .master_clk_i (clk),
    .master_rst_i (rst_n),
    .start_i      (start),
    .start_addr_i (start_addr),
    .byte_count_i (byte_count),
    .busy_o       (busy),
    .done_o       (done),
    .rd_if        (bus),
    .SS           (ss),
    .SCK_SPI      (sck),
    .MOSI         (mosi),
    .MISO         (miso)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic [7:0] flash_bytes [8];

  // Monitor state, written only by the monitor process
  int          cyc = 0;
  logic        ss_prev = 1'b1;
  logic        sck_prev = 1'b0;
  int          fcnt = 0;
  int          rcnt = 0;
  int          ss_falls = 0;
  int          ss_fall_cyc = 0;
  int          last_rise_cyc = 0;
  int          lead = 0;
  int          max_gap = 0;
  int          sck_rises = 0;
  logic [31:0] mosi_word = '0;
  logic [7:0]  got_bytes [$];
  int          done_cnt = 0;
  int          done_cyc = 0;
  int          consume_cyc = 0;

  always @(negedge clk) begin
    cyc++;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (bus.data_valid_o && bus.data_ready_i) begin
      got_bytes.push_back(bus.data_o);
      consume_cyc = cyc;
    end
    if (ss) begin
      fcnt = 0;
      rcnt = 0;
      miso = 1'b0;
    end else begin
      if (ss_prev) begin
        ss_falls++;
        ss_fall_cyc = cyc;
        mosi_word   = '0;
        max_gap     = 0;
      end
      if (sck && !sck_prev) begin
        sck_rises++;
        if (rcnt < 32) mosi_word = {mosi_word[30:0], mosi};
        if (rcnt == 0) lead = cyc - ss_fall_cyc;
        else if (cyc - last_rise_cyc > max_gap) max_gap = cyc - last_rise_cyc;
        last_rise_cyc = cyc;
        rcnt++;
      end
      if (!sck && sck_prev) begin
        fcnt++;
        if (fcnt >= 32 && fcnt < 96) begin
          miso = flash_bytes[(fcnt - 32) / 8][7 - ((fcnt - 32) % 8)];
        end
      end
    end
    ss_prev  = ss;
    sck_prev = sck;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [23:0] addr, input logic [15:0] cnt);
    start_addr = addr;
    byte_count = cnt;
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    check_eq(tag, done, 1);
  endtask

  function automatic logic [7:0] got_at(input int idx);
    if (idx < got_bytes.size()) return got_bytes[idx];
    return 8'hxx;
  endfunction

  int base_rx, base_rises, base_done, base_falls, r_mid, n;

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    start_addr = '0;
    byte_count = '0;
    bus.data_ready_i = 1'b1;
    for (int i = 0; i < 8; i++) flash_bytes[i] = 8'h00;
    repeat (3) tick();

    check_eq("rst_ss", ss, 1);
    check_eq("rst_sck", sck, 0);
    check_eq("rst_mosi", mosi, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_valid", bus.data_valid_o, 0);
    check_eq("rst_data", bus.data_o, 8'h00);
    rst_n = 1'b1;
    repeat (2) tick();

    // T2 header
    flash_bytes[0] = 8'h5A;
    base_rx = got_bytes.size(); base_rises = sck_rises; base_done = done_cnt; base_falls = ss_falls;
    do_start(24'h012345, 16'd1);
    check_eq("t2_busy", busy, 1);
    check_eq("t2_ss_low", ss, 0);
    wait_done("t2_done", 2000);
    check_eq("t2_busy_done", busy, 1);
    tick();
    check_eq("t2_busy_drop", busy, 0);
    check_eq("t2_header", mosi_word, 32'h03012345);
    check_eq("t2_lead_ge_div", lead >= 4, 1);
    check_eq("t2_period", max_gap, 8);
    check_eq("t2_rises", sck_rises - base_rises, 40);
    check_eq("t2_byte", got_at(base_rx), 8'h5A);
    check_eq("t2_nbytes", got_bytes.size() - base_rx, 1);
    check_eq("t2_ss_falls", ss_falls - base_falls, 1);
    check_eq("t2_ss_high", ss, 1);
    repeat (20) tick();

    // T3 stream with ready tied high
    flash_bytes[0] = 8'hA5; flash_bytes[1] = 8'h3C; flash_bytes[2] = 8'hFF; flash_bytes[3] = 8'h00;
    base_rx = got_bytes.size(); base_rises = sck_rises; base_done = done_cnt;
    do_start(24'h000000, 16'd4);
    wait_done("t3_done", 3000);
    tick();
    check_eq("t3_nbytes", got_bytes.size() - base_rx, 4);
    check_eq("t3_b0", got_at(base_rx), 8'hA5);
    check_eq("t3_b1", got_at(base_rx + 1), 8'h3C);
    check_eq("t3_b2", got_at(base_rx + 2), 8'hFF);
    check_eq("t3_b3", got_at(base_rx + 3), 8'h00);
    check_eq("t3_no_stall", max_gap, 8);
    check_eq("t3_rises", sck_rises - base_rises, 64);
    check_eq("t3_done_once", done_cnt - base_done, 1);
    check_eq("t3_done_after_consume", done_cyc > consume_cyc, 1);
    repeat (20) tick();

    // T4 backpressure
    flash_bytes[0] = 8'h11; flash_bytes[1] = 8'h22; flash_bytes[2] = 8'h33;
    base_rx = got_bytes.size(); base_rises = sck_rises; base_done = done_cnt;
    bus.data_ready_i = 1'b0;
    do_start(24'h000010, 16'd3);
    n = 0;
    while (bus.data_valid_o !== 1'b1 && n < 2000) begin tick(); n++; end
    check_eq("t4_first_valid", bus.data_valid_o, 1);
    repeat (100) tick();
    r_mid = sck_rises;
    repeat (100) tick();
    check_eq("t4_sck_frozen", sck_rises, r_mid);
    check_eq("t4_rises_held", sck_rises - base_rises, 48);
    check_eq("t4_sck_low", sck, 0);
    check_eq("t4_data_stable", bus.data_o, 8'h11);
    check_eq("t4_valid_held", bus.data_valid_o, 1);
    check_eq("t4_busy", busy, 1);
    bus.data_ready_i = 1'b1;
    wait_done("t4_done", 2000);
    tick();
    check_eq("t4_nbytes", got_bytes.size() - base_rx, 3);
    check_eq("t4_b0", got_at(base_rx), 8'h11);
    check_eq("t4_b1", got_at(base_rx + 1), 8'h22);
    check_eq("t4_b2", got_at(base_rx + 2), 8'h33);
    check_eq("t4_done_once", done_cnt - base_done, 1);
    repeat (20) tick();

    // T5 zero length
    base_rises = sck_rises; base_falls = ss_falls; base_done = done_cnt;
    do_start(24'h000020, 16'd0);
    check_eq("t5_done", done, 1);
    check_eq("t5_busy", busy, 1);
    check_eq("t5_ss", ss, 1);
    tick();
    check_eq("t5_done_pulse", done, 0);
    check_eq("t5_busy_drop", busy, 0);
    repeat (20) tick();
    check_eq("t5_no_ss_fall", ss_falls - base_falls, 0);
    check_eq("t5_no_sck", sck_rises - base_rises, 0);
    check_eq("t5_done_once", done_cnt - base_done, 1);

    // T6 start while busy, issued mid-address
    flash_bytes[0] = 8'h77;
    base_rx = got_bytes.size(); base_falls = ss_falls; base_done = done_cnt;
    do_start(24'hABCDEF, 16'd1);
    repeat (100) tick();
    do_start(24'h000100, 16'd5);
    wait_done("t6_done", 2000);
    repeat (300) tick();
    check_eq("t6_header", mosi_word, 32'h03ABCDEF);
    check_eq("t6_nbytes", got_bytes.size() - base_rx, 1);
    check_eq("t6_byte", got_at(base_rx), 8'h77);
    check_eq("t6_done_once", done_cnt - base_done, 1);
    check_eq("t6_ss_falls", ss_falls - base_falls, 1);

    // T1 reset mid-DATA
    flash_bytes[0] = 8'hAA; flash_bytes[1] = 8'hBB;
    base_rises = sck_rises; base_done = done_cnt;
    do_start(24'h000200, 16'd2);
    n = 0;
    while (sck_rises - base_rises < 36 && n < 2000) begin tick(); n++; end
    check_eq("t1_reached_data", sck_rises - base_rises >= 36, 1);
    rst_n = 1'b0;
    tick();
    check_eq("t1_ss", ss, 1);
    check_eq("t1_sck", sck, 0);
    check_eq("t1_valid", bus.data_valid_o, 0);
    check_eq("t1_busy", busy, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    r_mid = sck_rises;
    repeat (100) tick();
    check_eq("t1_no_done", done_cnt - base_done, 0);
    check_eq("t1_ss_idle", ss, 1);
    check_eq("t1_sck_idle", sck_rises, r_mid);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
